// File: rtl/chain_mon_pkg.sv
// chain_mon_pkg: shared FSM state type and width helpers for the chain skew monitor
package chain_mon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_CAPTURE,
        S_REPORT,
        S_DONE
    } mon_state_t;

    localparam int WIN_W = 16;

    function automatic int idx_width(input int n_chains);
        return (n_chains > 2) ? $clog2(n_chains - 1) : 1;
    endfunction

    function automatic int ctr_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/inv_chain_param.sv
// inv_chain_param: a single chain of STAGES inverters
module inv_chain_param #(
    parameter int STAGES = 3
) (
    input  logic din,
    output logic dout
);

    logic [STAGES:0] n;

    assign n[0] = din;
    for (genvar i = 0; i < STAGES; i++) begin : g_inv
        assign n[i+1] = ~n[i];
    end
    assign dout = n[STAGES];

endmodule

// File: rtl/chain_skew_monitor.sv
// chain_skew_monitor: launches one edge into N matched chains and counts per-pair capture mismatches
module chain_skew_monitor
    import chain_mon_pkg::*;
#(
    parameter  int N_CHAINS = 4,
    parameter  int STAGES   = 3,
    parameter  int CNT_W    = 16,
    parameter  int SETTLE   = 2,
    localparam int IDX_W    = idx_width(N_CHAINS)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIN_W-1:0]    window,
    input  logic [N_CHAINS-1:0] test_flip,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDX_W-1:0]    res_idx,
    output logic [CNT_W-1:0]    res_count,
    output logic                done,
    output logic [N_CHAINS-1:0] chain_out
);

    localparam int SW = ctr_width(SETTLE);
    localparam int NP = N_CHAINS - 1;

    mon_state_t          state_q, state_d;
    logic                launch_q;
    logic [WIN_W-1:0]    win_q;
    logic [WIN_W-1:0]    lcnt;
    logic [SW-1:0]       scnt;
    logic [IDX_W-1:0]    rep_idx;
    logic [CNT_W-1:0]    cnt [NP];
    logic [N_CHAINS-1:0] cap;

    for (genvar i = 0; i < N_CHAINS; i++) begin : g_chain
        (* dont_touch = "true" *)
        inv_chain_param #(.STAGES(STAGES)) u_chain (
            .din  (launch_q),
            .dout (chain_out[i])
        );
    end

    assign cap = chain_out ^ test_flip;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = state_q != S_IDLE;
        res_valid = state_q == S_REPORT;
        done      = state_q == S_DONE;
        res_idx   = rep_idx;
        res_count = cnt[rep_idx];
        case (state_q)
            S_IDLE:    if (start) state_d = (window == '0) ? S_REPORT : S_LAUNCH;
            S_LAUNCH:  state_d = S_SETTLE;
            S_SETTLE:  if (scnt == SW'(SETTLE - 1)) state_d = S_CAPTURE;
            S_CAPTURE: state_d = (lcnt + 1'b1 == win_q) ? S_REPORT : S_LAUNCH;
            S_REPORT:  if (res_ready && rep_idx == IDX_W'(N_CHAINS - 2)) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            launch_q <= 1'b0;
            win_q    <= '0;
            lcnt     <= '0;
            scnt     <= '0;
            rep_idx  <= '0;
            for (int k = 0; k < NP; k++) cnt[k] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    win_q   <= window;
                    lcnt    <= '0;
                    rep_idx <= '0;
                    for (int k = 0; k < NP; k++) cnt[k] <= '0;
                end
                S_LAUNCH: begin
                    launch_q <= ~launch_q;
                    scnt     <= '0;
                end
                S_SETTLE: scnt <= scnt + 1'b1;
                S_CAPTURE: begin
                    lcnt <= lcnt + 1'b1;
                    // saturate rather than wrap so a long window never reads as few mismatches
                    for (int k = 0; k < NP; k++)
                        if (cap[0] != cap[k+1] && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
                end
                S_REPORT: if (res_ready && rep_idx != IDX_W'(N_CHAINS - 2)) rep_idx <= rep_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chain_skew_monitor.sv
// tb_chain_skew_monitor: scoreboard bench for chain_skew_monitor with a 4-bit counter build
module tb_chain_skew_monitor;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int ST   = 2;
    localparam int MAXC = 15;

    logic          sys_clk = 0;
    logic          rst;
    logic          start;
    logic [15:0]   window;
    logic [N-1:0]  test_flip;
    logic          busy, res_valid, res_ready, done;
    logic [1:0]    res_idx;
    logic [CW-1:0] res_count;
    logic [N-1:0]  chain_out;

    int total = 0;
    int bad   = 0;
    int q_idx[$];
    int q_cnt[$];

    chain_skew_monitor #(.N_CHAINS(N), .STAGES(3), .CNT_W(CW), .SETTLE(ST)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .window    (window),
        .test_flip (test_flip),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx),
        .res_count (res_count),
        .done      (done),
        .chain_out (chain_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!rst && res_valid && res_ready) begin
            check("sb_nonempty", int'(q_idx.size() > 0), 1);
            if (q_idx.size() > 0) begin
                check("res_idx", int'(res_idx), q_idx.pop_front());
                check("res_count", int'(res_count), q_cnt.pop_front());
            end
        end
    end

    task automatic run(input int win, input logic [N-1:0] flip, input bit stall);
        int n;
        int dn;
        int hi;
        int hc;
        for (int k = 0; k < N - 1; k++) begin
            q_idx.push_back(k);
            q_cnt.push_back((flip[0] ^ flip[k+1]) ? ((win > MAXC) ? MAXC : win) : 0);
        end
        window    = 16'(win);
        test_flip = flip;
        res_ready = !stall;
        start     = 1;
        @(posedge sys_clk); #1;
        start = 0;
        check("busy_on_start", int'(busy), 1);
        n = 0;
        while (!res_valid && n < 2000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check("meas_cycles", n, win * (ST + 2));
        if (stall) begin
            hi = int'(res_idx);
            hc = int'(res_count);
            for (int c = 0; c < 5; c++) begin
                start  = (c == 1);
                window = (c == 1) ? 16'd3 : window;
                @(posedge sys_clk); #1;
                check("hold_valid", int'(res_valid), 1);
                check("hold_idx", int'(res_idx), hi);
                check("hold_count", int'(res_count), hc);
            end
            start     = 0;
            res_ready = 1;
        end
        dn = 0;
        n  = 0;
        while (busy && n < 200) begin
            @(posedge sys_clk); #1;
            dn += int'(done);
            n++;
        end
        check("done_pulses", dn, 1);
        check("sb_drained", q_idx.size(), 0);
        check("idle_valid", int'(res_valid), 0);
        @(posedge sys_clk); #1;
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] co;
        rst = 1; start = 0; window = 0; test_flip = 0; res_ready = 1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_idx", int'(res_idx), 0);
        check("rst_count", int'(res_count), 0);
        check("rst_chain", int'(chain_out), 4'hF);
        rst = 0;
        run(10, 4'b0000, 0);
        run(10, 4'b0100, 0);
        run(20, 4'b0010, 0);
        run(10, 4'b0100, 1);
        window = 10; test_flip = 4'b0100; start = 1;
        @(posedge sys_clk); #1;
        start = 0;
        repeat (13) @(posedge sys_clk);
        #1;
        check("mid_busy", int'(busy), 1);
        #2 rst = 1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(res_valid), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_idx", int'(res_idx), 0);
        check("mid_rst_count", int'(res_count), 0);
        check("mid_rst_chain", int'(chain_out), 4'hF);
        @(posedge sys_clk); #1;
        rst = 0;
        run(2, 4'b0000, 0);
        co = chain_out;
        run(0, 4'b0110, 0);
        check("win0_no_toggle", int'(chain_out), int'(co));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
